// File: rtl/three_phase_demod.sv
// three_phase_demod: recovers amplitude and phase from three 120-degree phases.
// Clarke transform, CORDIC vectoring and 1/K gain correction, one step per edge.
module three_phase_demod #(
  parameter int ITERATIONS     = 18,
  parameter int INTERNAL_WIDTH = 24
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [18:0] Input1,
  input  logic [18:0] Input2,
  input  logic [18:0] Input3,
  output logic        Out_Valid,
  output logic [18:0] Amplitude,
  output logic [17:0] Phase
);

  localparam int W   = INTERNAL_WIDTH;
  localparam int F   = W - 3;
  localparam int CSH = 36 - F;
  localparam int PW  = W + 19;
  localparam int IW  = $clog2(ITERATIONS + 1);

  localparam logic signed [39:0]   K3  = 40'sd87381;
  localparam logic signed [39:0]   KS3 = 40'sd151349;
  localparam logic signed [PW-1:0] KG  = PW'(159189);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLARKE,
    S_QUAD,
    S_ITER,
    S_GAIN,
    S_OUT
  } state_e;

  state_e state_q, state_d;

  logic signed [18:0]   s1_q, s1_d;
  logic signed [18:0]   s2_q, s2_d;
  logic signed [18:0]   s3_q, s3_d;
  logic signed [W-1:0]  x_q, x_d;
  logic signed [W-1:0]  y_q, y_d;
  logic [17:0]          z_q, z_d;
  logic [IW-1:0]        i_q, i_d;
  logic                 zero_q, zero_d;
  logic [18:0]          m_q, m_d;
  logic [18:0]          amp_q, amp_d;
  logic [17:0]          ph_q, ph_d;
  logic                 ov_q, ov_d;

  function automatic logic [17:0] atan_lut(input logic [IW-1:0] k);
    logic [17:0] r;
    case (int'(k))
      0:       r = 18'd32768;
      1:       r = 18'd19344;
      2:       r = 18'd10221;
      3:       r = 18'd5188;
      4:       r = 18'd2604;
      5:       r = 18'd1303;
      6:       r = 18'd652;
      7:       r = 18'd326;
      8:       r = 18'd163;
      9:       r = 18'd81;
      10:      r = 18'd41;
      11:      r = 18'd20;
      12:      r = 18'd10;
      13:      r = 18'd5;
      14:      r = 18'd3;
      15:      r = 18'd1;
      16:      r = 18'd1;
      default: r = 18'd0;
    endcase
    return r;
  endfunction

  // Clarke terms; results kept with three fraction guard bits
  logic signed [20:0]   sum_y, sum_x;
  logic signed [39:0]   py, px;
  logic signed [W-1:0]  y_cl, x_cl;

  assign sum_y = {s1_q[18], s1_q, 1'b0}
               - {{2{s2_q[18]}}, s2_q}
               - {{2{s3_q[18]}}, s3_q};
  assign sum_x = {{2{s2_q[18]}}, s2_q}
               - {{2{s3_q[18]}}, s3_q};
  assign py    = 40'(sum_y) * K3;
  assign px    = 40'(sum_x) * KS3;
  assign y_cl  = W'(py >>> CSH);
  assign x_cl  = W'(px >>> CSH);

  logic signed [W-1:0]  xs, ys;
  assign xs = x_q >>> i_q;
  assign ys = y_q >>> i_q;

  logic signed [PW-1:0] pm, m_full;
  logic [18:0]          m_sat;
  assign pm     = PW'(x_q) * KG;
  assign m_full = pm >>> F;

  always_comb begin
    m_sat = m_full[18:0];
    if (m_full[PW-1]) begin
      m_sat = '0;
    end else if (m_full > PW'(262143)) begin
      m_sat = 19'h3FFFF;
    end
  end

  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    zero_d  = zero_q;
    m_d     = m_q;
    amp_d   = amp_q;
    ph_d    = ph_q;
    ov_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (In_Valid) begin
          s1_d    = Input1;
          s2_d    = Input2;
          s3_d    = Input3;
          state_d = S_CLARKE;
        end
      end
      S_CLARKE: begin
        x_d     = x_cl;
        y_d     = y_cl;
        state_d = S_QUAD;
      end
      S_QUAD: begin
        if (x_q[W-1]) begin
          x_d = -x_q;
          y_d = -y_q;
          z_d = 18'h20000;
        end else begin
          z_d = '0;
        end
        i_d     = '0;
        zero_d  = (x_q == '0) && (y_q == '0);
        state_d = S_ITER;
      end
      S_ITER: begin
        // a null vector has no angle, so z stays put
        if (!zero_q) begin
          if (!y_q[W-1]) begin
            x_d = x_q + ys;
            y_d = y_q - xs;
            z_d = z_q + atan_lut(i_q);
          end else begin
            x_d = x_q - ys;
            y_d = y_q + xs;
            z_d = z_q - atan_lut(i_q);
          end
        end
        i_d = i_q + IW'(1);
        if (i_q == IW'(ITERATIONS - 1)) begin
          state_d = S_GAIN;
        end
      end
      S_GAIN: begin
        m_d     = m_sat;
        state_d = S_OUT;
      end
      S_OUT: begin
        amp_d   = m_q;
        ph_d    = z_q;
        ov_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      m_q     <= '0;
      amp_q   <= '0;
      ph_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      m_q     <= m_d;
      amp_q   <= amp_d;
      ph_q    <= ph_d;
      ov_q    <= ov_d;
    end
  end

  assign In_Ready  = (state_q == S_IDLE);
  assign Out_Valid = ov_q;
  assign Amplitude = amp_q;
  assign Phase     = ph_q;

endmodule
